// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type encoding, field position, default sizes.
package noc_pkg;

    localparam int unsigned PORTS_DEF     = 7;
    localparam int unsigned FLIT_SIZE_DEF = 32;

    // The flit type occupies the top FT_WIDTH bits of every flit.
    localparam int unsigned FT_WIDTH = 2;

    typedef enum logic [FT_WIDTH-1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic {
        LK_IDLE   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_t;

    typedef logic [$clog2(PORTS_DEF)-1:0] port_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, cyclically.
module rr_arbiter #(
    parameter int unsigned PORTS = noc_pkg::PORTS_DEF
) (
    input  logic [PORTS-1:0]         req,
    input  logic [$clog2(PORTS)-1:0] ptr,
    output logic [PORTS-1:0]         grant
);

    localparam int unsigned IDXW = $clog2(PORTS);

    logic [IDXW-1:0] idx;
    logic            found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            idx = IDXW'((32'(ptr) + k) % PORTS);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_alloc_stage.sv
// Switch allocation + traversal stage: per-output round-robin arbitration with
// wormhole locking, registering winning flits and crossbar selects.
module sw_alloc_stage
    import noc_pkg::*;
#(
    parameter int unsigned PORTS     = PORTS_DEF,
    parameter int unsigned FLIT_SIZE = FLIT_SIZE_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [PORTS-1:0]                      in_valid,
    input  logic [PORTS-1:0][FLIT_SIZE-1:0]       in_flit,
    input  logic [PORTS-1:0][$clog2(PORTS)-1:0]   in_route,
    output logic [PORTS-1:0]                      in_ready,
    output logic [PORTS-1:0][FLIT_SIZE-1:0]       xbar_din,
    output logic [PORTS-1:0][$clog2(PORTS)-1:0]   xbar_dest,
    output logic [PORTS-1:0]                      out_valid,
    input  logic [PORTS-1:0]                      out_ready
);

    localparam int unsigned IDXW = $clog2(PORTS);

    logic [PORTS-1:0]                 ent_valid;
    logic [PORTS-1:0][FLIT_SIZE-1:0]  ent_flit;
    logic [PORTS-1:0][IDXW-1:0]       ent_dest;

    lock_state_t                      lock_q [PORTS];
    lock_state_t                      lock_d [PORTS];
    logic [PORTS-1:0][IDXW-1:0]       owner_q, owner_d;
    logic [PORTS-1:0][IDXW-1:0]       ptr_q, ptr_d;

    flit_type_t                       ftype [PORTS];
    logic [PORTS-1:0]                 out_free;
    logic [PORTS-1:0]                 entry_free;
    // Matrices below are indexed [output][input].
    logic [PORTS-1:0][PORTS-1:0]      head_req;
    logic [PORTS-1:0][PORTS-1:0]      arb_gnt;
    logic [PORTS-1:0][PORTS-1:0]      grant;
    logic [IDXW-1:0]                  own;

    assign xbar_din  = ent_flit;
    assign xbar_dest = ent_dest;

    always_comb begin
        out_valid = '0;
        for (int unsigned o = 0; o < PORTS; o++) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (ent_valid[i] && ent_dest[i] == IDXW'(o)) out_valid[o] = 1'b1;
            end
        end
        out_free = ~out_valid | out_ready;
    end

    // An input may only be refilled if its own entry is empty or leaving now,
    // even when that entry targets a different output than the new flit.
    always_comb begin
        head_req = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            ftype[i]      = flit_type_t'(in_flit[i][FLIT_SIZE-1 -: FT_WIDTH]);
            entry_free[i] = !ent_valid[i] || out_ready[ent_dest[i]];
        end
        for (int unsigned o = 0; o < PORTS; o++) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                head_req[o][i] = in_valid[i] && entry_free[i] &&
                                 in_route[i] == IDXW'(o) &&
                                 (ftype[i] == FT_HEAD || ftype[i] == FT_SINGLE);
            end
        end
    end

    for (genvar g = 0; g < PORTS; g++) begin : g_arb
        rr_arbiter #(.PORTS(PORTS)) u_arb (
            .req   (head_req[g]),
            .ptr   (ptr_q[g]),
            .grant (arb_gnt[g])
        );
    end

    always_comb begin
        grant = '0;
        own   = '0;
        for (int unsigned o = 0; o < PORTS; o++) begin
            if (out_free[o]) begin
                if (lock_q[o] == LK_IDLE) begin
                    grant[o] = arb_gnt[o];
                end else begin
                    own = owner_q[o];
                    if (in_valid[own] && entry_free[own] && in_route[own] == IDXW'(o) &&
                        (ftype[own] == FT_BODY || ftype[own] == FT_TAIL))
                        grant[o][own] = 1'b1;
                end
            end
        end
        in_ready = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            for (int unsigned o = 0; o < PORTS; o++) in_ready[i] = in_ready[i] | grant[o][i];
        end
        if (!rst_n) in_ready = '0;
    end

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        for (int unsigned o = 0; o < PORTS; o++) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (grant[o][i]) begin
                    if (lock_q[o] == LK_IDLE) begin
                        ptr_d[o] = IDXW'((i + 1) % PORTS);
                        if (ftype[i] == FT_HEAD) begin
                            lock_d[o]  = LK_LOCKED;
                            owner_d[o] = IDXW'(i);
                        end
                    end else if (ftype[i] == FT_TAIL) begin
                        lock_d[o] = LK_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned o = 0; o < PORTS; o++) lock_q[o] <= LK_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_flit  <= '0;
            ent_dest  <= '0;
        end else begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (in_ready[i]) begin
                    ent_valid[i] <= 1'b1;
                    ent_flit[i]  <= in_flit[i];
                    ent_dest[i]  <= in_route[i];
                end else if (ent_valid[i] && out_ready[ent_dest[i]]) begin
                    ent_valid[i] <= 1'b0;
                    ent_flit[i]  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sw_alloc_stage.sv
// Directed scoreboard bench for sw_alloc_stage (7 ports, 32-bit flits).
module tb_sw_alloc_stage;
    import noc_pkg::*;

    localparam int unsigned P = 7;
    localparam int unsigned W = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [P-1:0]        in_valid;
    logic [P-1:0][W-1:0] in_flit;
    logic [P-1:0][2:0]   in_route;
    logic [P-1:0]        in_ready;
    logic [P-1:0][W-1:0] xbar_din;
    logic [P-1:0][2:0]   xbar_dest;
    logic [P-1:0]        out_valid;
    logic [P-1:0]        out_ready;

    typedef struct {
        int unsigned port;
        logic [W-1:0] flit;
        logic [2:0]   dest;
    } exp_t;

    exp_t        sb [$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    sw_alloc_stage #(.PORTS(P), .FLIT_SIZE(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_route  (in_route),
        .in_ready  (in_ready),
        .xbar_din  (xbar_din),
        .xbar_dest (xbar_dest),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clr();
        in_valid  = '0;
        in_flit   = '0;
        in_route  = '0;
        out_ready = '1;
    endtask

    task automatic set_in(input int unsigned i, input logic [W-1:0] f, input int unsigned r);
        in_valid[i] = 1'b1;
        in_flit[i]  = f;
        in_route[i] = 3'(r);
    endtask

    // Check in_ready against the expected grant set, record accepted flits,
    // clock once, then verify each accepted flit on the registered outputs.
    task automatic step(input string tag, input logic [P-1:0] exp_ready);
        exp_t e;
        #1;
        chk({tag, ".in_ready"}, 256'(in_ready), 256'(exp_ready));
        for (int unsigned i = 0; i < P; i++) begin
            if (exp_ready[i]) begin
                e.port = i; e.flit = in_flit[i]; e.dest = in_route[i];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".xbar_din"},  256'(xbar_din[e.port]),  256'(e.flit));
            chk({tag, ".xbar_dest"}, 256'(xbar_dest[e.port]), 256'(e.dest));
            chk({tag, ".out_valid"}, 256'(out_valid[e.dest]), 256'(1'b1));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        set_in(0, 32'hC000_0001, 1);
        #3;
        chk("rst.in_ready",  256'(in_ready),  256'(0));
        chk("rst.xbar_din",  256'(xbar_din),  256'(0));
        chk("rst.xbar_dest", 256'(xbar_dest), 256'(0));
        chk("rst.out_valid", 256'(out_valid), 256'(0));
        #9;
        rst_n = 1'b1;
        clr();

        // Single flit
        set_in(2, 32'hC000_0ABC, 4);
        step("single", 7'b0000100);
        for (int unsigned i = 0; i < P; i++)
            if (i != 2) chk("single.others_zero", 256'(xbar_din[i]), 256'(0));
        clr();
        step("single_drain", 7'b0);
        chk("single_drain.out_valid", 256'(out_valid), 256'(0));
        chk("single_drain.xbar_din",  256'(xbar_din),  256'(0));

        // Protocol boundaries: out-of-range route and BODY to an idle output
        set_in(0, 32'hC000_0077, 7);
        set_in(1, 32'h0000_0055, 2);
        step("bad_route_body", 7'b0);
        clr();

        // Round-robin contention on output 0
        set_in(1, 32'hC000_0011, 0);
        set_in(3, 32'hC000_0033, 0);
        set_in(5, 32'hC000_0055, 0);
        for (int unsigned r = 0; r < 2; r++) begin
            step("rr", 7'b0000010);
            step("rr", 7'b0001000);
            step("rr", 7'b0100000);
        end
        clr();
        step("rr_drain", 7'b0);

        // Wormhole lock on output 6
        set_in(0, 32'h4000_0A00, 6);
        set_in(2, 32'hC000_0B02, 6);
        step("worm.head", 7'b0000001);
        set_in(0, 32'h0000_0A01, 6);
        step("worm.body1", 7'b0000001);
        set_in(0, 32'h0000_0A02, 6);
        step("worm.body2", 7'b0000001);
        set_in(0, 32'h8000_0A03, 6);
        step("worm.tail", 7'b0000001);
        in_valid[0] = 1'b0;
        step("worm.single", 7'b0000100);
        clr();
        step("worm_drain", 7'b0);

        // Backpressure on output 3
        set_in(4, 32'h4000_0300, 3);
        step("bp.head", 7'b0010000);
        set_in(4, 32'h0000_0301, 3);
        out_ready[3] = 1'b0;
        for (int unsigned c = 0; c < 5; c++) begin
            step("bp.stall", 7'b0);
            chk("bp.hold_din",   256'(xbar_din[4]),  256'(32'h4000_0300));
            chk("bp.hold_valid", 256'(out_valid[3]), 256'(1'b1));
        end
        out_ready[3] = 1'b1;
        step("bp.refill", 7'b0010000);
        set_in(4, 32'h8000_0302, 3);
        step("bp.tail", 7'b0010000);
        clr();
        step("bp_drain", 7'b0);

        // Full parallel load: i -> (i+3) mod 7
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned i = 0; i < P; i++)
                set_in(i, 32'hC000_0000 | (c << 8) | i, (i + 3) % P);
            step("full", 7'h7f);
            chk("full.out_valid", 256'(out_valid), 256'(7'h7f));
        end
        clr();
        step("full_drain", 7'b0);

        // Reset mid-packet, then a new head from another input to the same output
        set_in(1, 32'h4000_0500, 5);
        step("rstmid.head", 7'b0000010);
        clr();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid.xbar_din",  256'(xbar_din),  256'(0));
        chk("rstmid.xbar_dest", 256'(xbar_dest), 256'(0));
        chk("rstmid.out_valid", 256'(out_valid), 256'(0));
        set_in(3, 32'h4000_0503, 5);
        #1;
        chk("rstmid.in_ready", 256'(in_ready), 256'(0));
        #1;
        rst_n = 1'b1;
        step("rstmid.newhead", 7'b0001000);
        clr();
        step("rstmid_drain", 7'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
